// File: rtl/matrix_framebuffer_scan_if.sv
// matrix_framebuffer_scan_if: pixel write/query bus between the game controller and the framebuffer.
interface matrix_framebuffer_scan_if;
    logic       wr_valid;
    logic [7:0] wr_pos;
    logic       wr_set;
    logic       wr_ready;
    logic       clear_all;
    logic [7:0] rd_pos;
    logic       rd_hit;
    modport master (output wr_valid, wr_pos, wr_set, clear_all, rd_pos, input wr_ready, rd_hit);
    modport slave (input wr_valid, wr_pos, wr_set, clear_all, rd_pos, output wr_ready, rd_hit);
endinterface

// File: rtl/matrix_framebuffer_scan.sv
// matrix_framebuffer_scan: 8x16 framebuffer with pixel writes/queries and row-multiplexed LED matrix scan.
module matrix_framebuffer_scan #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    matrix_framebuffer_scan_if.slave    pix,
    output logic                        frame_start,
    output logic [7:0]                  MATRIX_ROW,
    output logic [15:0]                 MATRIX_COL
);
    localparam int DW = $clog2(SCAN_DIV);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t         state, nextState;
    logic [2:0]     clrRow, nextClrRow, rowIdx;
    logic [DW-1:0]  divCnt;
    logic [15:0]    fb [8];
    logic           wrEn, divWrap, blank;
    // clear_all during CLEAR restarts the sweep from row 0
    always_comb begin
        nextState = state;
        nextClrRow = clrRow;
        if (state == CLEAR) begin
            nextClrRow = pix.clear_all ? 3'd0 : clrRow + 3'd1;
            nextState = (!pix.clear_all && clrRow == 3'd7) ? IDLE : CLEAR;
        end else if (pix.clear_all) begin
            nextState = CLEAR;
            nextClrRow = 3'd0;
        end
    end
    assign pix.wr_ready = (state == IDLE) && !pix.clear_all;
    assign wrEn = pix.wr_valid && pix.wr_ready && !pix.wr_pos[7];
    assign divWrap = divCnt == DW'(SCAN_DIV - 1);
    assign blank = divCnt < DW'(BLANK_CYCLES);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            clrRow <= '0;
            divCnt <= '0;
            rowIdx <= '0;
            frame_start <= 1'b0;
            MATRIX_ROW <= '0;
            MATRIX_COL <= '0;
            pix.rd_hit <= 1'b0;
            for (int i = 0; i < 8; i++) fb[i] <= '0;
        end else begin
            state <= nextState;
            clrRow <= nextClrRow;
            if (state == CLEAR) fb[clrRow] <= '0;
            if (wrEn) fb[pix.wr_pos[6:4]][pix.wr_pos[3:0]] <= pix.wr_set;
            pix.rd_hit <= !pix.rd_pos[7] && fb[pix.rd_pos[6:4]][pix.rd_pos[3:0]];
            divCnt <= divWrap ? '0 : divCnt + 1'b1;
            rowIdx <= rowIdx + 3'(divWrap);
            frame_start <= divWrap && rowIdx == 3'd7;
            // dark window at the start of each row suppresses ghosting
            MATRIX_ROW <= blank ? 8'd0 : 8'd1 << rowIdx;
            MATRIX_COL <= blank ? 16'd0 : fb[rowIdx];
        end
    end
endmodule

// File: tb/tb_matrix_framebuffer_scan.sv
// tb_matrix_framebuffer_scan: randomized and directed checks against a cycle-count based framebuffer model.
module tb_matrix_framebuffer_scan;
    localparam int SD = 8;
    localparam int BC = 2;
    logic        clk = 1'b0;
    logic        reset;
    logic        frameStart;
    logic [7:0]  matRow;
    logic [15:0] matCol;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl [8];
    int          n;
    int          clearLeft;
    matrix_framebuffer_scan_if pix();
    matrix_framebuffer_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) u_dut (
        .clk(clk), .reset(reset), .pix(pix),
        .frame_start(frameStart), .MATRIX_ROW(matRow), .MATRIX_COL(matCol)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // model: n edges since reset gives scan position; clearLeft counts remaining clear-sweep rows
    task automatic tick();
        logic [15:0] expCol;
        logic [7:0]  expRow;
        logic        expHit, expReady, expFs;
        int          r;
        #1;
        expReady = (clearLeft == 0) && !pix.clear_all;
        if (!reset) check("wr_ready", 32'(pix.wr_ready), 32'(expReady));
        if (reset) begin
            expRow = 0;
            expCol = 0;
            expHit = 0;
            n = 0;
            clearLeft = 8;
            for (int i = 0; i < 8; i++) mdl[i] = '0;
            expFs = 0;
        end else begin
            r = (n / SD) % 8;
            expRow = (n % SD < BC) ? 8'd0 : 8'(1 << r);
            expCol = (n % SD < BC) ? 16'd0 : mdl[r];
            expHit = !pix.rd_pos[7] && mdl[pix.rd_pos[6:4]][pix.rd_pos[3:0]];
            if (pix.wr_valid && expReady && !pix.wr_pos[7]) mdl[pix.wr_pos[6:4]][pix.wr_pos[3:0]] = pix.wr_set;
            if (clearLeft > 0) begin
                mdl[8 - clearLeft] = '0;
                clearLeft--;
            end
            if (pix.clear_all) clearLeft = 8;
            n++;
            expFs = (n % (8 * SD)) == 0;
        end
        @(posedge clk);
        #1;
        check("rd_hit", 32'(pix.rd_hit), 32'(expHit));
        check("MATRIX_ROW", 32'(matRow), 32'(expRow));
        check("MATRIX_COL", 32'(matCol), 32'(expCol));
        check("frame_start", 32'(frameStart), 32'(expFs));
    endtask
    task automatic drive(input logic v, input logic [7:0] wp, input logic s, input logic c, input logic [7:0] rp);
        pix.wr_valid = v;
        pix.wr_pos = wp;
        pix.wr_set = s;
        pix.clear_all = c;
        pix.rd_pos = rp;
        tick();
    endtask
    initial begin
        n = 0;
        clearLeft = 8;
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00);
        reset = 1'b0;
        repeat (10) drive(0, 8'h00, 0, 0, 8'($urandom));
        drive(1, 8'h25, 1, 0, 8'h00);
        drive(0, 8'h00, 0, 0, 8'h25);
        repeat (70) drive(0, 8'h00, 0, 0, 8'($urandom));
        drive(1, 8'h9A, 1, 0, 8'h9A);
        drive(0, 8'h00, 0, 0, 8'h9A);
        drive(1, 8'h13, 1, 0, 8'h13);
        drive(0, 8'h00, 0, 0, 8'h13);
        repeat (400) drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 49) == 0, 8'($urandom));
        repeat (40) drive(1, {1'b0, 7'($urandom)}, 1, 0, 8'($urandom));
        drive(1, 8'h40, 1, 1, 8'h40);
        for (int i = 0; i < 8; i++) drive(0, 8'h00, 0, 0, 8'(i * 16));
        for (int i = 0; i < 128; i++) drive(0, 8'h00, 0, 0, 8'(i));
        repeat (30) drive(1, {1'b0, 7'($urandom)}, 1, 0, 8'($urandom));
        drive(0, 8'h00, 0, 1, 8'h00);
        repeat (3) drive(1, 8'h11, 1, 0, 8'($urandom));
        drive(0, 8'h00, 0, 1, 8'h00);
        repeat (10) drive(1, 8'h22, 1, 0, 8'($urandom));
        for (int i = 0; i < 128; i++) drive(0, 8'h00, 0, 0, 8'(i));
        repeat (30) drive(1, {1'b0, 7'($urandom)}, 1, 0, 8'($urandom));
        repeat (27) drive(0, 8'h00, 0, 0, 8'($urandom));
        reset = 1'b1;
        drive(0, 8'h00, 0, 0, 8'h00);
        reset = 1'b0;
        repeat (150) drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 8'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
